// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the multi-channel LFSR random source:
// FSM state encoding, maximal-length tap masks and channel rotation.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lfsr_fsm_t;

  // Maximal-length XNOR tap set for widths 3..32 (XAPP052 taps, bit index - 1).
  function automatic logic [31:0] lfsr_tap_mask(input int width);
    case (width)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Rotate the low 'width' bits of value left by 'amount' (amount < width).
  function automatic logic [31:0] rotl(input logic [31:0] value, input int width,
                                       input int amount);
    logic [63:0] mask;
    logic [63:0] shifted;
    mask    = (64'd1 << width) - 64'd1;
    shifted = (64'(value) & mask) << amount;
    return 32'((shifted & mask) | (shifted >> width));
  endfunction

endpackage

// File: rtl/lfsr_rng_multi_if.sv
// Seed handshake and random-sample stream of the multi-channel LFSR source.
interface lfsr_rng_multi_if #(
  parameter int NUM_BITS = 8,
  parameter int NUM_CH   = 2
);
  logic                       seed_valid;
  logic [NUM_BITS-1:0]        seed_data;
  logic                       seed_ready;
  logic [NUM_CH*NUM_BITS-1:0] rand_data;
  logic                       rand_valid;
  logic                       period_done;

  // Consumer side: offers seeds, receives samples.
  modport master (
    output seed_valid, seed_data,
    input  seed_ready, rand_data, rand_valid, period_done
  );

  // Generator side.
  modport slave (
    input  seed_valid, seed_data,
    output seed_ready, rand_data, rand_valid, period_done
  );
endinterface

// File: rtl/lfsr_core.sv
// XNOR-feedback Fibonacci LFSR state register with seed load and
// lock-up recovery. Sequencing (when to step or load) comes from the top.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int                  NUM_BITS     = 8,
  parameter logic [NUM_BITS-1:0] SEED_DEFAULT = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [NUM_BITS-1:0] load_data,
  output logic [NUM_BITS-1:0] state,
  output logic                lockup_flag
);

  localparam logic [31:0]         TAP_FULL = lfsr_tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAP_MASK = TAP_FULL[NUM_BITS-1:0];

  logic [NUM_BITS-1:0] state_q;
  logic                lockup_q;
  logic                fb;
  logic                state_all_ones;
  logic                seed_all_ones;
  logic [NUM_BITS-1:0] next_state;

  assign fb             = ~^(state_q & TAP_MASK);
  assign next_state     = {state_q[NUM_BITS-2:0], fb};
  assign state_all_ones = &state_q;
  assign seed_all_ones  = &load_data;

  assign state       = state_q;
  assign lockup_flag = lockup_q;

  // State register: seed load beats lock-up recovery beats normal stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state_q  <= SEED_DEFAULT;
      lockup_q <= 1'b0;
    end else if (load) begin
      if (seed_all_ones) begin
        state_q  <= SEED_DEFAULT;
        lockup_q <= 1'b1;
      end else begin
        state_q  <= load_data;
        lockup_q <= 1'b0;
      end
    end else if (state_all_ones) begin
      // All-ones is a fixed point of XNOR feedback; escape it regardless of en.
      state_q  <= SEED_DEFAULT;
      lockup_q <= 1'b1;
    end else if (en) begin
      state_q <= next_state;
    end
  end

endmodule

// File: rtl/lfsr_rng_multi.sv
// Multi-channel pseudo-random source: run/stop/one-shot control, seed
// handshake, exact period counter and rotated per-channel outputs.
module lfsr_rng_multi
  import lfsr_pkg::*;
#(
  parameter int                  NUM_BITS     = 8,
  parameter int                  NUM_CH       = 2,
  parameter int                  ROT_STEP     = 1,
  parameter logic [NUM_BITS-1:0] SEED_DEFAULT = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic            oneshot,
  output logic            lockup_flag,
  lfsr_rng_multi_if.slave bus
);

  // Index of the last sample in a period: P-1 = 2^NUM_BITS - 2.
  localparam logic [NUM_BITS-1:0] LAST_STEP = {{(NUM_BITS-1){1'b1}}, 1'b0};

  lfsr_fsm_t           fsm_q;
  logic [NUM_BITS-1:0] step_cnt_q;
  logic                oneshot_q;
  logic [NUM_BITS-1:0] state;
  logic                in_run;
  logic                at_last;
  logic                seed_accept;
  logic                core_en;

  assign in_run      = (fsm_q == RUN);
  assign at_last     = (step_cnt_q == LAST_STEP);
  assign seed_accept = bus.seed_valid && !in_run;
  // A stop seen in RUN freezes the state at the sample currently shown.
  assign core_en     = in_run && !stop;

  // Moore outputs decoded straight from the state registers.
  assign bus.seed_ready  = !in_run;
  assign bus.rand_valid  = in_run;
  assign bus.period_done = in_run && at_last;

  lfsr_core #(
    .NUM_BITS    (NUM_BITS),
    .SEED_DEFAULT(SEED_DEFAULT)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (core_en),
    .load       (seed_accept),
    .load_data  (bus.seed_data),
    .state      (state),
    .lockup_flag(lockup_flag)
  );

  // Control FSM and period counter; the counter is held at zero outside RUN
  // so every run, and every seed load, starts counting from sample 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= IDLE;
      step_cnt_q <= '0;
      oneshot_q  <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE, DONE: begin
          step_cnt_q <= '0;
          if (stop) begin
            fsm_q <= IDLE;
          end else if (start) begin
            fsm_q     <= RUN;
            oneshot_q <= oneshot;
          end
        end
        RUN: begin
          if (stop) begin
            fsm_q <= IDLE;
          end else if (at_last) begin
            step_cnt_q <= '0;
            if (oneshot_q) fsm_q <= DONE;
          end else begin
            step_cnt_q <= step_cnt_q + 1'b1;
          end
        end
        default: begin
          fsm_q      <= IDLE;
          step_cnt_q <= '0;
        end
      endcase
    end
  end

  // Channel c sees the state rotated left by (c*ROT_STEP) mod NUM_BITS.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int ROT_AMT = (c * ROT_STEP) % NUM_BITS;
    logic [31:0] rot_full;
    assign rot_full = rotl(32'(state), NUM_BITS, ROT_AMT);
    assign bus.rand_data[c*NUM_BITS +: NUM_BITS] = rot_full[NUM_BITS-1:0];
    if (NUM_BITS < 32) begin : g_pad
      logic unused_rot_hi;
      assign unused_rot_hi = ^rot_full[31:NUM_BITS];
    end
  end

endmodule

// File: tb/tb_lfsr_rng_multi.sv
// Directed bench: a 4-bit/2-channel/rotate-1 instance for sequencing,
// handshake and lock-up behaviour, and an 8-bit/rotate-0 instance for
// free-running period pulses and asynchronous reset.
module tb_lfsr_rng_multi;

  logic clk = 1'b0;
  logic rst_n;
  logic start4, stop4, oneshot4, lock4;
  logic start8, stop8, oneshot8, lock8;

  int checks = 0;
  int errors = 0;

  // Hand-derived 4-bit sequence from seed 0 with taps at bits 3 and 2.
  logic [3:0] seq4 [15] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                            4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};

  always #5 clk = ~clk;

  lfsr_rng_multi_if #(.NUM_BITS(4), .NUM_CH(2)) bus4 ();
  lfsr_rng_multi_if #(.NUM_BITS(8), .NUM_CH(2)) bus8 ();

  lfsr_rng_multi #(
    .NUM_BITS(4), .NUM_CH(2), .ROT_STEP(1), .SEED_DEFAULT(4'h0)
  ) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop4),
    .oneshot(oneshot4), .lockup_flag(lock4), .bus(bus4)
  );

  lfsr_rng_multi #(
    .NUM_BITS(8), .NUM_CH(2), .ROT_STEP(0), .SEED_DEFAULT(8'h00)
  ) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .stop(stop8),
    .oneshot(oneshot8), .lockup_flag(lock8), .bus(bus8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int first_pd;
    int second_pd;
    int pd_count;

    rst_n = 1'b0;
    start4 = 1'b0; stop4 = 1'b0; oneshot4 = 1'b0;
    start8 = 1'b0; stop8 = 1'b0; oneshot8 = 1'b0;
    bus4.seed_valid = 1'b0; bus4.seed_data = 4'h0;
    bus8.seed_valid = 1'b0; bus8.seed_data = 8'h00;
    tick(1);

    // Reset values.
    check("rst_rand_data", bus4.rand_data, 8'h00);
    check("rst_seed_ready", bus4.seed_ready, 1'b1);
    check("rst_rand_valid", bus4.rand_valid, 1'b0);
    check("rst_period_done", bus4.period_done, 1'b0);
    check("rst_lockup", lock4, 1'b0);
    rst_n = 1'b1;
    tick(1);

    // Free run from seed 0: both channels follow the sequence.
    start4 = 1'b1; oneshot4 = 1'b0;
    tick(1);
    start4 = 1'b0;
    check("run_valid", bus4.rand_valid, 1'b1);
    check("run_seed_ready", bus4.seed_ready, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("run_ch0", bus4.rand_data[3:0], seq4[i]);
      check("run_ch1", bus4.rand_data[7:4], {seq4[i][2:0], seq4[i][3]});
      tick(1);
    end

    // Stop in RUN: IDLE next cycle, state frozen at B.
    stop4 = 1'b1;
    tick(1);
    stop4 = 1'b0;
    check("stop_valid", bus4.rand_valid, 1'b0);
    check("stop_ready", bus4.seed_ready, 1'b1);
    check("stop_state", bus4.rand_data[3:0], 4'hB);
    tick(2);
    check("stop_hold", bus4.rand_data[3:0], 4'hB);

    // start and stop together in IDLE: stay in IDLE.
    start4 = 1'b1; stop4 = 1'b1;
    tick(1);
    start4 = 1'b0; stop4 = 1'b0;
    check("startstop_valid", bus4.rand_valid, 1'b0);
    tick(1);
    check("startstop_valid2", bus4.rand_valid, 1'b0);
    check("startstop_state", bus4.rand_data[3:0], 4'hB);

    // All-ones seed is rejected; a later good seed clears the flag.
    bus4.seed_valid = 1'b1; bus4.seed_data = 4'hF;
    tick(1);
    check("seedF_state", bus4.rand_data[3:0], 4'h0);
    check("seedF_lock", lock4, 1'b1);
    bus4.seed_data = 4'h5;
    tick(1);
    bus4.seed_valid = 1'b0;
    check("seed5_state", bus4.rand_data, 8'hA5);
    check("seed5_lock", lock4, 1'b0);

    // One-shot run seeded with 7 in the same cycle as start.
    bus4.seed_valid = 1'b1; bus4.seed_data = 4'h7;
    start4 = 1'b1; oneshot4 = 1'b1;
    tick(1);
    bus4.seed_valid = 1'b0; start4 = 1'b0; oneshot4 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("os_valid", bus4.rand_valid, 1'b1);
      check("os_state", bus4.rand_data[3:0], seq4[(i + 3) % 15]);
      check("os_period_done", bus4.period_done, (i == 14));
      // A seed and start offered mid-run must be ignored.
      if (i == 5) begin
        bus4.seed_valid = 1'b1; bus4.seed_data = 4'h2; start4 = 1'b1;
      end else begin
        bus4.seed_valid = 1'b0; start4 = 1'b0;
      end
      tick(1);
    end
    check("done_valid", bus4.rand_valid, 1'b0);
    check("done_ready", bus4.seed_ready, 1'b1);
    check("done_state", bus4.rand_data[3:0], 4'h7);
    check("done_pd", bus4.period_done, 1'b0);
    tick(2);
    check("done_hold", bus4.rand_data[3:0], 4'h7);

    // Restart from DONE, then upset the state to all-ones.
    start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    check("restart_valid", bus4.rand_valid, 1'b1);
    check("restart_state", bus4.rand_data[3:0], 4'h7);
    check("lock_pre", lock4, 1'b0);
    force u4.u_core.state_q = 4'hF;
    tick(1);
    release u4.u_core.state_q;
    check("lock_upset", lock4, 1'b1);
    check("lock_valid", bus4.rand_valid, 1'b1);
    tick(1);
    check("lock_sticky", lock4, 1'b1);
    stop4 = 1'b1;
    tick(1);
    stop4 = 1'b0;
    check("lock_stop_valid", bus4.rand_valid, 1'b0);

    // 8-bit free run for 600 cycles: pulses at samples 254 and 509.
    first_pd = -1; second_pd = -1; pd_count = 0;
    start8 = 1'b1;
    tick(1);
    start8 = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (bus8.period_done) begin
        pd_count++;
        if (first_pd < 0) first_pd = cyc;
        else if (second_pd < 0) second_pd = cyc;
      end
      if (cyc == 0)   check("r8_s0", bus8.rand_data[7:0], 8'h00);
      if (cyc == 1)   check("r8_s1", bus8.rand_data[7:0], 8'h01);
      if (cyc == 2)   check("r8_s2", bus8.rand_data[7:0], 8'h03);
      if (cyc == 255) check("r8_wrap", bus8.rand_data[7:0], 8'h00);
      if (cyc == 100) check("r8_rot0", bus8.rand_data[15:8], bus8.rand_data[7:0]);
      tick(1);
    end
    check("r8_pd_first", first_pd, 254);
    check("r8_pd_second", second_pd, 509);
    check("r8_pd_count", pd_count, 3'd2);
    check("r8_valid", bus8.rand_valid, 1'b1);

    // Asynchronous reset mid-run, sampled between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus8.rand_valid, 1'b0);
    check("arst_pd", bus8.period_done, 1'b0);
    check("arst_ready", bus8.seed_ready, 1'b1);
    check("arst_data8", bus8.rand_data, 16'h0000);
    check("arst_lock4", lock4, 1'b0);
    check("arst_data4", bus4.rand_data, 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_multi.md
Name: lfsr_rng_multi

Overview:
Parametrised multi-channel pseudo-random source for the stochastic-computing units. It holds one XNOR-feedback Fibonacci LFSR of width NUM_BITS, 3 to 32. It publishes NUM_CH rotated copies of the state so that downstream comparators receive weakly correlated random numbers. Over the single-width generator it adds:
- a run/stop/one-shot control FSM;
- a seed handshake;
- an exact period counter with a completion pulse;
- lock-up detection and recovery.

Parameters:
NUM_BITS, 8, LFSR width; legal range 3..32.
NUM_CH, 2, number of output channels; at least 1.
ROT_STEP, 1, left-rotation per channel index; channel c is rotated by (c*ROT_STEP) mod NUM_BITS; legal range 0..NUM_BITS-1.
SEED_DEFAULT, 0, reset and recovery state; must not be all-ones.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  begin a run (honoured in IDLE or DONE).
stop  in  1  abort to IDLE.
oneshot  in  1  1 = halt after one full period; 0 = free-run. Sampled only when a run starts.
seed_valid  in  1  seed offered.
seed_data  in  NUM_BITS  seed value.
seed_ready  out  1  seed can be accepted; high in IDLE and DONE.
rand_data  out  NUM_CH*NUM_BITS  channel c occupies bits [c*NUM_BITS +: NUM_BITS].
rand_valid  out  1  rand_data is a live sample; high in RUN.
period_done  out  1  one-cycle pulse on the last sample of a period.
lockup_flag  out  1  sticky; an all-ones state was seen or an all-ones seed was rejected.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE, state to SEED_DEFAULT, step_cnt to 0, latched oneshot to 0.
  - Outputs: seed_ready=1, rand_valid=0, period_done=0, lockup_flag=0.
  - rand_data shows the rotated SEED_DEFAULT.
- Feedback:
  - fb = ~^(state & TAP_MASK(NUM_BITS)).
  - Next state = {state[NUM_BITS-2:0], fb}.
  - TAP_MASK is the XAPP052 maximal-length tap set, with the bit index shifted down by one. Example for width 4: taps at bits 3 and 2.
  - Period is P = 2^NUM_BITS - 1. The all-ones state is the lock-up state.
- Outputs: channel c = rotate-left(state, (c*ROT_STEP) mod NUM_BITS). rand_data is purely combinational from state, with zero latency.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start moves to RUN. stop has priority over a simultaneous start and keeps the FSM in IDLE.
  - RUN: the state advances every cycle and step_cnt increments. start and seed_valid are ignored. stop moves to IDLE next cycle with state frozen.
  - At step_cnt == P-1 in RUN: period_done=1 in that cycle and step_cnt wraps to 0.
    - Latched oneshot=1: next FSM state is DONE, and the LFSR state equals the run's first sample.
    - Latched oneshot=0: the FSM stays in RUN.
  - DONE: state is held and rand_valid=0. start moves to RUN; stop moves to IDLE, with stop winning over start.
  - The first RUN cycle presents the starting state as sample 0, so a one-shot run yields exactly P valid samples.
- Seed handshake:
  - A seed is accepted when seed_valid and seed_ready are both high.
  - Acceptance loads state, clears step_cnt and clears lockup_flag.
  - If seed_data is all-ones, SEED_DEFAULT is loaded instead and lockup_flag is set.
  - Seed and start in the same cycle: the seed is loaded and the FSM enters RUN. The seed is sample 0.
- Lock-up recovery: if state is all-ones at any point (e.g. a bit upset), the next state is SEED_DEFAULT and lockup_flag is set. rand_valid is unaffected.
- Widths: step_cnt is NUM_BITS wide; the wrap compare is against P-1.
- Mid-run reset: rst_n low aborts immediately with no pending pulse.

Decomposition:
- Package lfsr_pkg holds:
  - a function lfsr_tap_mask(int width) returning a 32-bit mask for widths 3..32;
  - the enum lfsr_fsm_t {IDLE, RUN, DONE};
  - a function rotl for the channel rotation.
- Sub-module lfsr_core holds the state register, feedback, seed load and lock-up recovery. It takes enable/load controls from the FSM in the top level.

Test Plan:
- NUM_BITS=4, reset (seed 0), start with oneshot=0 -> state sequence 0,1,3,7,E,D,...; rand_valid high from the cycle after start.
- NUM_BITS=4, oneshot=1, start -> exactly 15 valid samples, all distinct and none equal to F. period_done high only on the 15th sample. FSM then reaches DONE holding 0, with seed_ready=1.
- NUM_CH=2, ROT_STEP=1, state 0001 -> ch0=0001, ch1=0010. With ROT_STEP=0, both channels are identical.
- Seed F offered in IDLE -> state=SEED_DEFAULT and lockup_flag=1. A later seed 5 -> state 5, lockup_flag=0.
- Force state F in RUN -> next state SEED_DEFAULT and lockup_flag=1. stop in RUN -> IDLE next cycle with state frozen. start plus stop in IDLE -> FSM stays in IDLE.
- Free-run NUM_BITS=8 for 600 cycles -> period_done pulses every 255 cycles. Assert rst_n mid-run -> all outputs at their reset values asynchronously.
